npu_custom_responder: RTL



---
 rtl/npu_cust_pkg.sv | 27 ++
 rtl/npu_requant_sat.sv | 31 +++
 rtl/npu_custom_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/npu_cust_pkg.sv
// Shared constants and types for the NPU CUSTOM-opcode responder.
// Opcode/funct values, FSM state type and int8 saturation bounds.
package npu_cust_pkg;

  localparam logic [6:0] OPC_CUSTOM = 7'b0000000;
  localparam logic [6:0] F7_CUSTOM  = 7'b0000000;

  localparam logic [2:0] F3_DOT4   = 3'b000;
  localparam logic [2:0] F3_MAC4   = 3'b001;
  localparam logic [2:0] F3_CLRACC = 3'b010;
  localparam logic [2:0] F3_RDACC  = 3'b011;
  localparam logic [2:0] F3_REQ    = 3'b100;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic cmd_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == F7_CUSTOM) && (f3 <= F3_REQ);
  endfunction

endpackage

// File: rtl/npu_requant_sat.sv
// Requantize: (acc + addend) arithmetic-shifted right, clamped to int8 and
// sign-extended back to ACC_W. Purely combinational.
module npu_requant_sat
  import npu_cust_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  input  logic [4:0]       shamt,
  output logic [ACC_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] LO = ACC_W'(INT8_MIN);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(INT8_MAX);

  logic signed [ACC_W-1:0] total;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    total   = acc + addend;
    shifted = total >>> shamt;
    if (shifted < LO)
      result = LO;
    else if (shifted > HI)
      result = HI;
    else
      result = shifted;
  end

endmodule

// File: rtl/npu_custom_responder.sv
// NPU responder for CUSTOM-opcode commands: int8 dot product, accumulate and
// requantize, returning a tagged 32-bit result over a valid/ready channel.
//
// state | meaning
// IDLE  | waiting for a command, req_ready high
// EXEC  | DOT4/MAC4 lane-serial multiply-add, or REQ single-cycle requantize
// RESP  | result registered; rsp_valid raised next cycle, held until retire
module npu_custom_responder
  import npu_cust_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic [4:0]       req_rd,
  input  logic [31:0]      req_rs1_val,
  input  logic [31:0]      req_rs2_val,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_rd,
  output logic [ACC_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  state_t           state;
  logic [1:0]       lane_cnt;
  logic [2:0]       f3_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  logic signed [7:0]  a_lane;
  logic signed [7:0]  b_lane;
  logic signed [15:0] prod;
  logic [ACC_W-1:0]   sum_next;
  logic [ACC_W-1:0]   mac_total;
  logic [ACC_W-1:0]   req_result;

  always_comb begin
    a_lane    = rs1_q[{lane_cnt, 3'b000} +: 8];
    b_lane    = rs2_q[{lane_cnt, 3'b000} +: 8];
    prod      = a_lane * b_lane;
    sum_next  = sum + ACC_W'(prod);
    mac_total = acc + sum_next;
  end

  npu_requant_sat #(.ACC_W(ACC_W)) u_requant (
    .acc    (acc),
    .addend (ACC_W'($signed(rs1_q))),
    .shamt  (rs2_q[4:0]),
    .result (req_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      sum       <= '0;
      lane_cnt  <= '0;
      f3_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_rd    <= req_rd;
            f3_q      <= req_funct3;
            rs1_q     <= req_rs1_val;
            rs2_q     <= req_rs2_val;
            sum       <= '0;
            lane_cnt  <= '0;
            rsp_err   <= 1'b0;
            if (!cmd_legal(req_funct3, req_funct7)) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
              state    <= RESP;
            end else begin
              case (req_funct3)
                F3_CLRACC: begin
                  acc      <= '0;
                  rsp_data <= '0;
                  state    <= RESP;
                end
                F3_RDACC: begin
                  rsp_data <= acc;
                  state    <= RESP;
                end
                default: state <= EXEC;
              endcase
            end
          end
        end
        EXEC: begin
          if (f3_q == F3_REQ) begin
            rsp_data <= req_result;
            state    <= RESP;
          end else begin
            sum      <= sum_next;
            lane_cnt <= lane_cnt + 2'd1;
            if (lane_cnt == LAST_LANE) begin
              state <= RESP;
              if (f3_q == F3_MAC4) begin
                acc      <= mac_total;
                rsp_data <= mac_total;
              end else begin
                rsp_data <= sum_next;
              end
            end
          end
        end
        RESP: begin
          // Result registers settle on RESP entry; valid follows one cycle later.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
